// File: rtl/mpmc11_app_cmd_gen.sv
// mpmc11 MIG command issuer: per-beat app_en/app_cmd/app_addr
// stream with read-return counting and completion pulse.
module mpmc11_app_cmd_gen #(
  parameter int ADDR_W   = 29,
  parameter int ADDR_INC = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              cmd_rd,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        burst_len,
  input  logic              abort,
  input  logic              app_rdy,
  input  logic              app_wdf_rdy,
  input  logic              app_rd_data_valid,
  output logic              app_en,
  output logic [2:0]        app_cmd,
  output logic [ADDR_W-1:0] app_addr,
  output logic              wdata_req,
  output logic              busy,
  output logic              done,
  output logic [7:0]        cmd_cnt,
  output logic [8:0]        rd_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CMD     = 2'd1,
    WAIT_RD = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        cmd_rd_q;
  logic [7:0]  len_q;
  logic [8:0]  exp_q;
  logic        abort_q;
  logic        acc;
  logic        last;
  logic [8:0]  rd_nxt;

  assign acc       = app_en & app_rdy & (cmd_rd_q | app_wdf_rdy);
  assign last      = (cmd_cnt == len_q) | abort_q | abort;
  assign rd_nxt    = rd_cnt + {8'd0, app_rd_data_valid};
  assign wdata_req = acc & ~cmd_rd_q;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: a read waits for all beats to return,
  // reads returned early are already in rd_cnt
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = CMD;
      CMD:     if (acc && last)
                 state_nxt = cmd_rd_q ? WAIT_RD : DONE;
      WAIT_RD: if (rd_nxt >= exp_q) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Burst datapath: command registers, counters, abort flag
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      app_en   <= 1'b0;
      app_cmd  <= 3'b000;
      app_addr <= '0;
      cmd_rd_q <= 1'b0;
      len_q    <= 8'd0;
      exp_q    <= 9'd0;
      abort_q  <= 1'b0;
      cmd_cnt  <= 8'd0;
      rd_cnt   <= 9'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            cmd_rd_q <= cmd_rd;
            len_q    <= burst_len;
            cmd_cnt  <= 8'd0;
            rd_cnt   <= 9'd0;
            abort_q  <= 1'b0;
            app_en   <= 1'b1;
            app_addr <= base_addr;
            app_cmd  <= {2'b00, cmd_rd};
          end
        end
        CMD: begin
          if (abort) abort_q <= 1'b1;
          if (app_rd_data_valid) rd_cnt <= rd_nxt;
          if (acc) begin
            app_addr <= app_addr + ADDR_W'(ADDR_INC);
            cmd_cnt  <= cmd_cnt + 8'd1;
            if (last) begin
              app_en <= 1'b0;
              exp_q  <= {1'b0, cmd_cnt} + 9'd1;
            end
          end
        end
        WAIT_RD: begin
          if (app_rd_data_valid) rd_cnt <= rd_nxt;
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mpmc11_app_cmd_gen.sv
// Scoreboard bench for mpmc11_app_cmd_gen: stimulus queues
// expected beats/completions, a negedge monitor checks them.
module tb_mpmc11_app_cmd_gen;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        cmd_rd = 1'b0;
  logic [28:0] base_addr = '0;
  logic [7:0]  burst_len = '0;
  logic        abort = 1'b0;
  logic        app_rdy = 1'b1;
  logic        app_wdf_rdy = 1'b1;
  logic        app_rd_data_valid = 1'b0;
  logic        app_en;
  logic [2:0]  app_cmd;
  logic [28:0] app_addr;
  logic        wdata_req;
  logic        busy;
  logic        done;
  logic [7:0]  cmd_cnt;
  logic [8:0]  rd_cnt;

  mpmc11_app_cmd_gen #(.ADDR_W(29), .ADDR_INC(8)) dut (
    .clk(clk), .rstn(rstn), .start(start), .cmd_rd(cmd_rd),
    .base_addr(base_addr), .burst_len(burst_len),
    .abort(abort), .app_rdy(app_rdy),
    .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data_valid(app_rd_data_valid),
    .app_en(app_en), .app_cmd(app_cmd),
    .app_addr(app_addr), .wdata_req(wdata_req),
    .busy(busy), .done(done),
    .cmd_cnt(cmd_cnt), .rd_cnt(rd_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  cmd;
    logic [28:0] addr;
    int          cyc;
  } beat_t;

  typedef struct {
    int          cyc;
    logic [7:0]  cc;
    logic [8:0]  rc;
  } done_t;

  beat_t bq[$];
  done_t dq[$];
  int cyc = 0;
  int checks = 0;
  int failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h cyc=%0d",
               name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_burst(bit rd, logic [28:0] base,
                            int n, int s);
    logic [28:0] a;
    for (int i = 0; i < n; i++) begin
      a = base + 29'(8 * i);
      bq.push_back('{cmd: {2'b00, rd}, addr: a,
                     cyc: s + 1 + i});
    end
  endtask

  task automatic push_done(int c, logic [7:0] cc,
                           logic [8:0] rc);
    dq.push_back('{cyc: c, cc: cc, rc: rc});
  endtask

  // Monitor: checks every accepted beat and every done pulse
  always @(negedge clk) begin
    beat_t b;
    done_t d;
    if (rstn) begin
      chk("wdata_req", wdata_req,
          app_en & app_rdy & app_wdf_rdy & ~app_cmd[0]);
      if (app_en & app_rdy & (app_cmd[0] | app_wdf_rdy)) begin
        if (bq.size() == 0) begin
          chk("unexpected_beat", app_addr, 64'hdead);
        end else begin
          b = bq.pop_front();
          chk("beat_cmd", app_cmd, b.cmd);
          chk("beat_addr", app_addr, b.addr);
          chk("beat_cyc", cyc, b.cyc);
        end
      end
      if (done) begin
        if (dq.size() == 0) begin
          chk("unexpected_done", done, 0);
        end else begin
          d = dq.pop_front();
          chk("done_cyc", cyc, d.cyc);
          chk("done_cmd_cnt", cmd_cnt, d.cc);
          chk("done_rd_cnt", rd_cnt, d.rc);
        end
      end
    end
  end

  initial begin
    int s;
    repeat (3) tick();
    chk("rst_app_en", app_en, 0);
    chk("rst_app_cmd", app_cmd, 0);
    chk("rst_app_addr", app_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cnts", {cmd_cnt, rd_cnt}, 0);
    rstn = 1'b1;
    tick();

    // Write burst, no stalls
    s = cyc;
    start = 1; cmd_rd = 0; base_addr = 29'h100; burst_len = 3;
    push_burst(0, 29'h100, 4, s);
    push_done(s + 5, 8'd4, 9'd0);
    tick(); start = 0;
    chk("busy_in_cmd", busy, 1);
    repeat (5) tick();
    chk("busy_idle", busy, 0);

    // Read burst with stall and early return
    s = cyc;
    start = 1; cmd_rd = 1; base_addr = 29'h2000; burst_len = 1;
    app_rdy = 0;
    bq.push_back('{cmd: 3'b001, addr: 29'h2000, cyc: s + 2});
    bq.push_back('{cmd: 3'b001, addr: 29'h2008, cyc: s + 3});
    push_done(s + 7, 8'd2, 9'd2);
    tick(); start = 0;
    chk("stall_en", app_en, 1);
    chk("stall_addr", app_addr, 29'h2000);
    tick(); app_rdy = 1;
    tick(); app_rd_data_valid = 1;
    tick(); app_rd_data_valid = 0;
    tick();
    tick(); app_rd_data_valid = 1;
    tick(); app_rd_data_valid = 0;
    tick();

    // Write stall on data ready
    s = cyc;
    start = 1; cmd_rd = 0; base_addr = 29'h40; burst_len = 1;
    app_wdf_rdy = 0;
    bq.push_back('{cmd: 3'b000, addr: 29'h40, cyc: s + 4});
    bq.push_back('{cmd: 3'b000, addr: 29'h48, cyc: s + 5});
    push_done(s + 6, 8'd2, 9'd0);
    tick(); start = 0;
    tick();
    tick();
    chk("wdf_stall_cnt", cmd_cnt, 0);
    chk("wdf_stall_addr", app_addr, 29'h40);
    tick(); app_wdf_rdy = 1;
    repeat (3) tick();

    // Write abort on 3rd accept
    s = cyc;
    start = 1; cmd_rd = 0; base_addr = 29'h300; burst_len = 7;
    push_burst(0, 29'h300, 3, s);
    push_done(s + 4, 8'd3, 9'd0);
    tick(); start = 0;
    tick();
    tick(); abort = 1;
    tick(); abort = 0;
    repeat (2) tick();

    // Read abort: waits for 3 returns
    s = cyc;
    start = 1; cmd_rd = 1; base_addr = 29'h500; burst_len = 7;
    push_burst(1, 29'h500, 3, s);
    push_done(s + 7, 8'd3, 9'd3);
    tick(); start = 0;
    tick(); app_rd_data_valid = 1;
    tick(); app_rd_data_valid = 0; abort = 1;
    tick(); abort = 0;
    tick(); app_rd_data_valid = 1;
    tick();
    tick(); app_rd_data_valid = 0;
    tick();

    // 256-beat read with address wrap
    s = cyc;
    start = 1; cmd_rd = 1; base_addr = 29'h1FFFFFF0;
    burst_len = 255;
    push_burst(1, 29'h1FFFFFF0, 256, s);
    push_done(s + 258, 8'd0, 9'd256);
    tick(); start = 0; app_rd_data_valid = 1;
    repeat (255) tick();
    tick(); app_rd_data_valid = 0;
    chk("wrap_rd_cnt", rd_cnt, 256);
    repeat (2) tick();

    // start while busy is ignored
    s = cyc;
    start = 1; cmd_rd = 0; base_addr = 29'h700; burst_len = 3;
    push_burst(0, 29'h700, 4, s);
    push_done(s + 5, 8'd4, 9'd0);
    tick(); start = 0;
    tick(); start = 1; cmd_rd = 1; base_addr = 29'hFFF;
    burst_len = 0;
    tick(); start = 0;
    repeat (3) tick();

    // Reset mid-CMD
    start = 1; cmd_rd = 1; base_addr = 29'h800; burst_len = 7;
    app_rdy = 0;
    tick(); start = 0;
    tick();
    chk("pre_rst_en", app_en, 1);
    rstn = 0;
    #1;
    chk("async_rst_en", app_en, 0);
    chk("async_rst_cmd", app_cmd, 0);
    chk("async_rst_addr", app_addr, 0);
    chk("async_rst_busy", busy, 0);
    tick(); rstn = 1; app_rdy = 1;
    tick();

    // Single-beat write after reset
    s = cyc;
    start = 1; cmd_rd = 0; base_addr = 29'h10; burst_len = 0;
    push_burst(0, 29'h10, 1, s);
    push_done(s + 2, 8'd1, 9'd0);
    tick(); start = 0;
    repeat (3) tick();

    chk("beats_left", bq.size(), 0);
    chk("dones_left", dq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
